// File: rtl/can_rx_fifo.sv
// ============================================================================
// Module   : can_rx_fifo
// Purpose  : Receive-message FIFO between the CAN acceptance filter and host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int DATA_WIDTH  = 128,
  parameter int AFULL_LEVEL = 14
) (
  input  logic                      i_sys_clk,
  input  logic                      i_reset_n,
  input  logic                      i_rx_w_en,
  input  logic [DATA_WIDTH-1:0]     i_rx_fifo_w_data,
  input  logic                      i_rx_r_en,
  input  logic                      i_clear_status,
  output logic [DATA_WIDTH-1:0]     o_rx_fifo_r_data,
  output logic                      o_rx_r_valid,
  output logic                      o_rx_full,
  output logic                      o_rx_empty,
  output logic                      o_rx_almost_full,
  output logic [$clog2(DEPTH):0]    o_rx_count,
  output logic                      o_rx_overflow,
  output logic                      o_rx_underflow
);

  localparam int                C_AW        = $clog2(DEPTH);
  localparam int                C_CW        = C_AW + 1;
  localparam logic [C_CW-1:0]   C_CNT_FULL  = C_CW'(DEPTH);
  localparam logic [C_CW-1:0]   C_CNT_AFULL = C_CW'(AFULL_LEVEL);
  localparam logic [C_CW-1:0]   C_CNT_ONE   = C_CW'(1);
  localparam logic [C_AW-1:0]   C_PTR_ONE   = C_AW'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]       r_wr_ptr;
  logic [C_AW-1:0]       r_rd_ptr;
  logic [C_CW-1:0]       r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovf_set;
  logic w_unf_set;

  // Flags decode the count register only, so they never glitch on inputs.
  assign w_full    = (r_count == C_CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_rd_acc  = i_rx_r_en & ~w_empty;
  // A pop in the same cycle frees a slot, so a write at full still lands.
  assign w_wr_acc  = i_rx_w_en & (~w_full | w_rd_acc);
  assign w_ovf_set = i_rx_w_en & ~w_wr_acc;
  assign w_unf_set = i_rx_r_en & w_empty;

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge i_sys_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_rx_fifo_w_data;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;

      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end

      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
      end

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase

      // A new event in the clearing cycle must not be lost.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (i_clear_status) begin
        r_overflow <= 1'b0;
      end

      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (i_clear_status) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_rx_fifo_r_data = r_rd_data;
  assign o_rx_r_valid     = r_rd_valid;
  assign o_rx_full        = w_full;
  assign o_rx_empty       = w_empty;
  assign o_rx_almost_full = (r_count >= C_CNT_AFULL);
  assign o_rx_count       = r_count;
  assign o_rx_overflow    = r_overflow;
  assign o_rx_underflow   = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_can_rx_fifo.sv
// ============================================================================
// Module   : tb_can_rx_fifo
// Purpose  : Directed plus randomized bench for can_rx_fifo, queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_can_rx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 128;
  localparam int AF    = 14;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_en = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          full;
  logic          empty;
  logic          afull;
  logic [CW-1:0] count;
  logic          ovf;
  logic          unf;

  can_rx_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .AFULL_LEVEL(AF)
  ) dut (
    .i_sys_clk       (clk),
    .i_reset_n       (rst_n),
    .i_rx_w_en       (w_en),
    .i_rx_fifo_w_data(w_data),
    .i_rx_r_en       (r_en),
    .i_clear_status  (clr),
    .o_rx_fifo_r_data(r_data),
    .o_rx_r_valid    (r_valid),
    .o_rx_full       (full),
    .o_rx_empty      (empty),
    .o_rx_almost_full(afull),
    .o_rx_count      (count),
    .o_rx_overflow   (ovf),
    .o_rx_underflow  (unf)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of messages plus expected output registers.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data  = '0;
  bit            m_valid = 1'b0;
  bit            m_ovf   = 1'b0;
  bit            m_unf   = 1'b0;
  int            n_vec   = 0;
  int            n_err   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",       DW'(count),   DW'(q.size()));
    chk("empty",       DW'(empty),   DW'(q.size() == 0));
    chk("full",        DW'(full),    DW'(q.size() == DEPTH));
    chk("almost_full", DW'(afull),   DW'(q.size() >= AF));
    chk("r_valid",     DW'(r_valid), DW'(m_valid));
    chk("r_data",      r_data,       m_data);
    chk("overflow",    DW'(ovf),     DW'(m_ovf));
    chk("underflow",   DW'(unf),     DW'(m_unf));
  endtask

  task automatic step(input bit rn, input bit w, input logic [DW-1:0] wd,
                      input bit r, input bit c);
    bit rd_acc;
    bit wr_acc;
    rst_n  = rn;
    w_en   = w;
    w_data = wd;
    r_en   = r;
    clr    = c;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      rd_acc  = r && (q.size() != 0);
      wr_acc  = w && ((q.size() < DEPTH) || rd_acc);
      m_valid = rd_acc;
      if (c) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (w && !wr_acc) m_ovf = 1'b1;
      if (r && q.size() == 0) m_unf = 1'b1;
      if (rd_acc) m_data = q.pop_front();
      if (wr_acc) q.push_back(wd);
    end
    #1;
    check_all();
  endtask

  function automatic logic [DW-1:0] rnd_msg();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    // Reset held two cycles while the filter keeps writing.
    step(1'b0, 1'b1, DW'(32'h77), 1'b0, 1'b0);
    step(1'b0, 1'b1, DW'(32'h78), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Fill and drain.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++)  step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Overflow at full, drain, then clear.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, DW'(32'hDEAD), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++)  step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Simultaneous pop and write at full.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, DW'(32'hBEEF), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++)  step(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Underflow, simultaneous read/write on empty, then wrap with pairs.
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b1, rnd_msg(), 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, rnd_msg(), 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    end

    // Reset mid-traffic.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, rnd_msg(), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, DW'(32'hA5), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic with phases biased towards filling and draining.
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 60) % 2 == 0) ? 75 : 30;
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 99) < wp),
           rnd_msg(),
           ($urandom_range(0, 99) < (100 - wp)),
           ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
